// File: rtl/rv32i_issue_stage_if.sv
// Handshake and ALU-side bus between the instruction source, the issue stage and the ALU.
// The slave modport is the issue stage; the master modport is its environment.
interface rv32i_issue_stage_if;
  logic        instruction_valid;
  logic [31:0] instruction;
  logic        instruction_ready;
  logic        enable;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] register_data_1;
  logic [31:0] register_data_2;
  logic [31:0] register_data_out;
  logic        retire_valid;
  logic [4:0]  retire_rd;
  logic [31:0] retire_data;
  logic        illegal_instruction;

  modport slave (
    input  instruction_valid, instruction, register_data_out,
    output instruction_ready, enable, funct3, funct7, register_data_1, register_data_2,
           retire_valid, retire_rd, retire_data, illegal_instruction
  );

  modport master (
    output instruction_valid, instruction, register_data_out,
    input  instruction_ready, enable, funct3, funct7, register_data_1, register_data_2,
           retire_valid, retire_rd, retire_data, illegal_instruction
  );
endinterface

// File: rtl/rv32i_issue_stage.sv
// RV32I decode / register-read / writeback stage feeding a fixed-latency ALU.
// One instruction in flight: IDLE -> EXECUTE (ALU_LATENCY cycles) -> WRITEBACK -> IDLE.
module rv32i_issue_stage #(
  parameter int unsigned ALU_LATENCY = 1
) (
  input  logic                 clock,
  input  logic                 reset_n,
  rv32i_issue_stage_if.slave   bus,
  input  logic [4:0]           debug_addr,
  output logic [31:0]          debug_data
);

  localparam int unsigned XLEN  = 32;
  localparam int unsigned NREG  = 32;
  localparam int unsigned CNT_W = 3;
  localparam logic [6:0]  OPC_OP     = 7'b0110011;
  localparam logic [6:0]  OPC_OP_IMM = 7'b0010011;

  typedef enum logic [1:0] {IDLE, EXECUTE, WRITEBACK} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [4:0]       rd_q, rd_d;
  logic [XLEN-1:0]  regs [NREG];

  logic             ready_d, enable_d, retire_valid_d, illegal_d, reg_we_c;
  logic [2:0]       funct3_d;
  logic [6:0]       funct7_d;
  logic [XLEN-1:0]  data1_d, data2_d, retire_data_d;
  logic [4:0]       retire_rd_d;

  // Decode of the word currently offered on the bus
  logic [6:0]      opcode;
  logic [4:0]      rs1, rs2, rd;
  logic [2:0]      f3;
  logic            is_op, is_op_imm;
  logic [XLEN-1:0] imm_sext, rs1_val, rs2_val;

  assign opcode    = bus.instruction[6:0];
  assign rd        = bus.instruction[11:7];
  assign f3        = bus.instruction[14:12];
  assign rs1       = bus.instruction[19:15];
  assign rs2       = bus.instruction[24:20];
  assign is_op     = (opcode == OPC_OP);
  assign is_op_imm = (opcode == OPC_OP_IMM);
  assign imm_sext  = {{20{bus.instruction[31]}}, bus.instruction[31:20]};
  assign rs1_val   = (rs1 == 5'd0) ? '0 : regs[rs1];
  assign rs2_val   = (rs2 == 5'd0) ? '0 : regs[rs2];
  assign debug_data = (debug_addr == 5'd0) ? '0 : regs[debug_addr];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state and next values of every registered output
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    rd_d           = rd_q;
    ready_d        = bus.instruction_ready;
    enable_d       = bus.enable;
    funct3_d       = bus.funct3;
    funct7_d       = bus.funct7;
    data1_d        = bus.register_data_1;
    data2_d        = bus.register_data_2;
    retire_valid_d = 1'b0;
    retire_rd_d    = bus.retire_rd;
    retire_data_d  = bus.retire_data;
    illegal_d      = 1'b0;
    reg_we_c       = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.instruction_valid && bus.instruction_ready) begin
          if (is_op || is_op_imm) begin
            state_d  = EXECUTE;
            cnt_d    = CNT_W'(ALU_LATENCY - 1);
            rd_d     = rd;
            ready_d  = 1'b0;
            enable_d = 1'b1;
            funct3_d = f3;
            // funct7 only qualifies OP-IMM for the SRLI/SRAI pair
            funct7_d = (is_op || f3 == 3'b101) ? bus.instruction[31:25] : 7'd0;
            data1_d  = rs1_val;
            data2_d  = is_op ? rs2_val : imm_sext;
          end else begin
            illegal_d = 1'b1;
          end
        end
      end
      EXECUTE: begin
        if (cnt_q == '0) begin
          state_d  = WRITEBACK;
          enable_d = 1'b0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      WRITEBACK: begin
        state_d        = IDLE;
        ready_d        = 1'b1;
        retire_valid_d = 1'b1;
        retire_rd_d    = rd_q;
        retire_data_d  = bus.register_data_out;
        reg_we_c       = (rd_q != 5'd0);
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_q                    <= '0;
      bus.instruction_ready   <= 1'b1;
      bus.enable              <= 1'b0;
      bus.funct3              <= '0;
      bus.funct7              <= '0;
      bus.register_data_1     <= '0;
      bus.register_data_2     <= '0;
      bus.retire_valid        <= 1'b0;
      bus.retire_rd           <= '0;
      bus.retire_data         <= '0;
      bus.illegal_instruction <= 1'b0;
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else begin
      rd_q                    <= rd_d;
      bus.instruction_ready   <= ready_d;
      bus.enable              <= enable_d;
      bus.funct3              <= funct3_d;
      bus.funct7              <= funct7_d;
      bus.register_data_1     <= data1_d;
      bus.register_data_2     <= data2_d;
      bus.retire_valid        <= retire_valid_d;
      bus.retire_rd           <= retire_rd_d;
      bus.retire_data         <= retire_data_d;
      bus.illegal_instruction <= illegal_d;
      if (reg_we_c) regs[rd_q] <= bus.register_data_out;
    end
  end

endmodule

// File: tb/tb_rv32i_issue_stage.sv
// Self-checking bench for rv32i_issue_stage: directed cases plus random back-to-back
// instructions checked against an architectural RV32I model.
module tb_rv32i_issue_stage;
  localparam int unsigned L = 2;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [4:0]  debug_addr;
  logic [31:0] debug_data;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] ref_regs [32];
  logic [31:0] alu_pipe [L];

  rv32i_issue_stage_if bus();

  rv32i_issue_stage #(.ALU_LATENCY(L)) dut (
    .clock(clock), .reset_n(reset_n), .bus(bus.slave),
    .debug_addr(debug_addr), .debug_data(debug_data)
  );

  always #5 clock = ~clock;

  // Registered ALU model with latency L, driven only from the stage's outputs
  function automatic logic [31:0] alu_f(input logic [2:0] f3, input logic [6:0] f7,
                                        input logic [31:0] a, input logic [31:0] b);
    case (f3)
      3'd0: return (f7 == 7'h20) ? a - b : a + b;
      3'd1: return a << b[4:0];
      3'd2: return {31'd0, $signed(a) < $signed(b)};
      3'd3: return {31'd0, a < b};
      3'd4: return a ^ b;
      3'd5: return (f7 == 7'h20) ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
      3'd6: return a | b;
      default: return a & b;
    endcase
  endfunction

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < L; i++) alu_pipe[i] <= '0;
    end else begin
      if (bus.enable)
        alu_pipe[0] <= alu_f(bus.funct3, bus.funct7, bus.register_data_1, bus.register_data_2);
      for (int i = 1; i < L; i++) alu_pipe[i] <= alu_pipe[i-1];
    end
  end
  assign bus.register_data_out = alu_pipe[L-1];

  typedef struct {
    logic        legal;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] a, b, res;
  } exp_t;

  typedef struct {
    int          en_cnt;
    logic        unstable;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] d1, d2;
    int          retire_cnt;
    logic [4:0]  rrd;
    logic [31:0] rdata;
    int          illegal_cnt;
    int          ready_cycle;
    logic        ready_low;
  } obs_t;

  // Architectural meaning of an instruction against the model register file
  function automatic exp_t ref_exec(input logic [31:0] ins);
    exp_t e;
    int imm;
    logic is_op;
    longint unsigned p;
    is_op   = (ins[6:0] == 7'h33);
    e.legal = is_op || (ins[6:0] == 7'h13);
    e.rd    = ins[11:7];
    e.f3    = ins[14:12];
    e.a     = ref_regs[ins[19:15]];
    imm     = int'(ins[31:20]);
    if (imm >= 2048) imm -= 4096;
    e.b  = is_op ? ref_regs[ins[24:20]] : 32'(imm);
    e.f7 = (is_op || e.f3 == 3'd5) ? ins[31:25] : 7'd0;
    p = 1;
    repeat (int'(e.b[4:0])) p = p * 2;
    case (e.f3)
      3'd0: e.res = (is_op && ins[30]) ? e.a - e.b : e.a + e.b;
      3'd1: e.res = 32'(longint'(e.a) * p);
      3'd2: e.res = (int'(e.a) < int'(e.b)) ? 32'd1 : 32'd0;
      3'd3: e.res = (e.a < e.b) ? 32'd1 : 32'd0;
      3'd4: e.res = e.a ^ e.b;
      3'd5: e.res = (ins[30] && e.a[31]) ? ~32'(longint'(~e.a) / p) : 32'(longint'(e.a) / p);
      3'd6: e.res = e.a | e.b;
      default: e.res = e.a & e.b;
    endcase
    return e;
  endfunction

  function automatic void ref_commit(input logic [31:0] ins);
    exp_t e;
    e = ref_exec(ins);
    if (e.legal && e.rd != 5'd0) ref_regs[e.rd] = e.res;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [4:0]  rs1, rs2, rd;
    logic [2:0]  f3;
    logic [11:0] imm;
    logic [6:0]  f7;
    logic [6:0]  bad [4];
    int kind;
    bad  = '{7'h03, 7'h23, 7'h63, 7'h37};
    rs1  = 5'($urandom); rs2 = 5'($urandom); rd = 5'($urandom); f3 = 3'($urandom);
    kind = int'($urandom_range(0, 9));
    if (kind == 0) return {25'($urandom), bad[$urandom_range(0, 3)]};
    if (kind < 5) begin
      f7 = ((f3 == 3'd0 || f3 == 3'd5) && $urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
      return {f7, rs2, rs1, f3, rd, 7'h33};
    end
    imm = 12'($urandom);
    if (f3 == 3'd1) imm[11:5] = 7'h00;
    if (f3 == 3'd5) imm[11:5] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
    return {imm, rs1, f3, rd, 7'h13};
  endfunction

  // Offers one instruction at a falling edge and records L+2 cycles of behaviour
  task automatic issue(input logic [31:0] ins, output obs_t o);
    int w;
    o.en_cnt = 0; o.unstable = 1'b0; o.f3 = '0; o.f7 = '0; o.d1 = '0; o.d2 = '0;
    o.retire_cnt = 0; o.rrd = '0; o.rdata = '0; o.illegal_cnt = 0; o.ready_cycle = 0;
    o.ready_low = 1'b0;
    w = 0;
    while (bus.instruction_ready !== 1'b1 && w < 10) begin @(negedge clock); w++; end
    if (bus.instruction_ready !== 1'b1) begin
      checks++; errors++;
      $display("FAIL issue_ready_timeout: ready=%b required 1", bus.instruction_ready);
    end
    bus.instruction_valid = 1'b1;
    bus.instruction = ins;
    @(posedge clock);
    @(negedge clock);
    bus.instruction_valid = 1'b0;
    for (int k = 1; k <= int'(L) + 2; k++) begin
      if (k > 1) @(negedge clock);
      if (bus.enable === 1'b1) begin
        if (o.en_cnt == 0) begin
          o.f3 = bus.funct3; o.f7 = bus.funct7;
          o.d1 = bus.register_data_1; o.d2 = bus.register_data_2;
        end else if ({o.f3, o.f7, o.d1, o.d2} !== {bus.funct3, bus.funct7,
                     bus.register_data_1, bus.register_data_2}) begin
          o.unstable = 1'b1;
        end
        o.en_cnt++;
      end
      if (bus.illegal_instruction === 1'b1) o.illegal_cnt++;
      if (bus.retire_valid === 1'b1) begin
        o.retire_cnt++; o.rrd = bus.retire_rd; o.rdata = bus.retire_data;
      end
      if (bus.instruction_ready !== 1'b1) o.ready_low = 1'b1;
      else if (o.ready_cycle == 0) o.ready_cycle = k;
    end
  endtask

  task automatic test_reset();
    bus.instruction_valid = 1'b0;
    bus.instruction = '0;
    debug_addr = '0;
    reset_n = 1'b0;
    for (int i = 0; i < 32; i++) ref_regs[i] = '0;
    #12;
    checks++;
    if ({bus.enable, bus.retire_valid, bus.illegal_instruction, bus.funct3, bus.funct7,
         bus.retire_rd} !== 18'd0) begin
      errors++;
      $display("FAIL reset_ctrl: en=%b rv=%b ill=%b f3=%h f7=%h rrd=%0d required all 0",
               bus.enable, bus.retire_valid, bus.illegal_instruction, bus.funct3,
               bus.funct7, bus.retire_rd);
    end
    checks++;
    if ({bus.register_data_1, bus.register_data_2, bus.retire_data} !== 96'd0) begin
      errors++;
      $display("FAIL reset_data: d1=%h d2=%h rdata=%h required 0", bus.register_data_1,
               bus.register_data_2, bus.retire_data);
    end
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    checks++;
    if (bus.instruction_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: got %b required 1", bus.instruction_ready);
    end
    for (int i = 0; i < 32; i++) begin
      debug_addr = 5'(i);
      #1;
      checks++;
      if (debug_data !== 32'd0) begin
        errors++;
        $display("FAIL reset_reg x%0d: got %h required 0", i, debug_data);
      end
    end
  endtask

  task automatic test_addi();
    obs_t o;
    issue(32'h00500093, o);
    ref_commit(32'h00500093);
    checks++;
    if ({o.f3, o.f7, o.d1, o.d2} !== {3'd0, 7'd0, 32'd0, 32'd5}) begin
      errors++;
      $display("FAIL addi_operands: f3=%h f7=%h d1=%h d2=%h required 0 0 0 5",
               o.f3, o.f7, o.d1, o.d2);
    end
    checks++;
    if (o.en_cnt != int'(L) || o.unstable) begin
      errors++;
      $display("FAIL addi_enable: cycles=%0d unstable=%b required %0d and 0",
               o.en_cnt, o.unstable, L);
    end
    checks++;
    if (o.retire_cnt != 1 || o.rrd !== 5'd1 || o.rdata !== 32'd5) begin
      errors++;
      $display("FAIL addi_retire: n=%0d rd=%0d data=%h required 1 1 5",
               o.retire_cnt, o.rrd, o.rdata);
    end
    checks++;
    if (o.ready_cycle != int'(L) + 2) begin
      errors++;
      $display("FAIL addi_ready_latency: got %0d required %0d", o.ready_cycle, L + 2);
    end
    debug_addr = 5'd1;
    #1;
    checks++;
    if (debug_data !== 32'd5) begin
      errors++;
      $display("FAIL addi_debug_x1: got %h required 5", debug_data);
    end
  endtask

  task automatic test_sub();
    obs_t o;
    issue(32'h00700113, o);
    ref_commit(32'h00700113);
    checks++;
    if (o.rdata !== 32'd7) begin
      errors++;
      $display("FAIL sub_setup_x2: got %h required 7", o.rdata);
    end
    issue(32'h402081B3, o);
    ref_commit(32'h402081B3);
    checks++;
    if ({o.f3, o.f7, o.d1, o.d2} !== {3'd0, 7'h20, 32'd5, 32'd7}) begin
      errors++;
      $display("FAIL sub_operands: f3=%h f7=%h d1=%h d2=%h required 0 20 5 7",
               o.f3, o.f7, o.d1, o.d2);
    end
    debug_addr = 5'd3;
    #1;
    checks++;
    if (o.rdata !== 32'hFFFFFFFE || o.rrd !== 5'd3 || debug_data !== 32'hFFFFFFFE) begin
      errors++;
      $display("FAIL sub_result: retire=%h rd=%0d x3=%h required fffffffe 3 fffffffe",
               o.rdata, o.rrd, debug_data);
    end
  endtask

  task automatic test_neg_imm();
    obs_t o;
    issue(32'hFFF00113, o);
    ref_commit(32'hFFF00113);
    debug_addr = 5'd2;
    #1;
    checks++;
    if (o.d2 !== 32'hFFFFFFFF || o.rdata !== 32'hFFFFFFFF || debug_data !== 32'hFFFFFFFF) begin
      errors++;
      $display("FAIL neg_imm: d2=%h retire=%h x2=%h required ffffffff",
               o.d2, o.rdata, debug_data);
    end
  endtask

  task automatic test_x0();
    obs_t o;
    issue(32'h00900013, o);
    ref_commit(32'h00900013);
    debug_addr = 5'd0;
    #1;
    checks++;
    if (o.retire_cnt != 1 || o.rrd !== 5'd0 || o.rdata !== 32'd9 || debug_data !== 32'd0) begin
      errors++;
      $display("FAIL x0_write: n=%0d rd=%0d data=%h x0=%h required 1 0 9 0",
               o.retire_cnt, o.rrd, o.rdata, debug_data);
    end
  endtask

  task automatic test_illegal();
    obs_t o;
    issue(32'h0000A083, o);
    checks++;
    if (o.illegal_cnt != 1 || o.en_cnt != 0 || o.retire_cnt != 0 || o.ready_low) begin
      errors++;
      $display("FAIL illegal_lw: ill=%0d en=%0d ret=%0d ready_low=%b required 1 0 0 0",
               o.illegal_cnt, o.en_cnt, o.retire_cnt, o.ready_low);
    end
  endtask

  // A word offered while busy must be ignored, not decoded
  task automatic test_busy_ignore();
    int ill, ret;
    logic [31:0] rdata;
    ill = 0; ret = 0; rdata = '0;
    bus.instruction_valid = 1'b1;
    bus.instruction = 32'h00300213;
    @(posedge clock);
    @(negedge clock);
    bus.instruction = 32'h0000A083;
    for (int k = 1; k <= int'(L) + 2; k++) begin
      if (k > 1) @(negedge clock);
      if (bus.illegal_instruction === 1'b1) ill++;
      if (bus.retire_valid === 1'b1) begin ret++; rdata = bus.retire_data; end
      if (k == int'(L) + 1) bus.instruction_valid = 1'b0;
    end
    ref_commit(32'h00300213);
    checks++;
    if (ill != 0 || ret != 1 || rdata !== 32'd3) begin
      errors++;
      $display("FAIL busy_ignore: ill=%0d ret=%0d data=%h required 0 1 3", ill, ret, rdata);
    end
  endtask

  task automatic test_reset_mid_execute();
    obs_t o;
    int ret;
    ret = 0;
    bus.instruction_valid = 1'b1;
    bus.instruction = 32'h00500093;
    @(posedge clock);
    @(negedge clock);
    bus.instruction_valid = 1'b0;
    checks++;
    if (bus.enable !== 1'b1) begin
      errors++;
      $display("FAIL midreset_enable_before: got %b required 1", bus.enable);
    end
    reset_n = 1'b0;
    debug_addr = 5'd1;
    #1;
    checks++;
    if ({bus.enable, bus.retire_valid, bus.illegal_instruction, bus.funct3, bus.funct7,
         bus.register_data_1, bus.register_data_2, debug_data} !== 109'd0) begin
      errors++;
      $display("FAIL midreset_outputs: en=%b rv=%b d1=%h d2=%h x1=%h required 0",
               bus.enable, bus.retire_valid, bus.register_data_1, bus.register_data_2,
               debug_data);
    end
    for (int i = 0; i < 32; i++) ref_regs[i] = '0;
    repeat (L + 3) begin
      @(negedge clock);
      if (bus.retire_valid === 1'b1) ret++;
    end
    reset_n = 1'b1;
    @(negedge clock);
    if (bus.retire_valid === 1'b1) ret++;
    checks++;
    if (ret != 0 || bus.instruction_ready !== 1'b1) begin
      errors++;
      $display("FAIL midreset_release: retires=%0d ready=%b required 0 1",
               ret, bus.instruction_ready);
    end
    issue(32'h00500093, o);
    ref_commit(32'h00500093);
    debug_addr = 5'd1;
    #1;
    checks++;
    if (o.retire_cnt != 1 || o.rdata !== 32'd5 || debug_data !== 32'd5) begin
      errors++;
      $display("FAIL midreset_repeat: n=%0d data=%h x1=%h required 1 5 5",
               o.retire_cnt, o.rdata, debug_data);
    end
  endtask

  task automatic test_back_to_back();
    obs_t o;
    exp_t e;
    logic [31:0] ins;
    for (int n = 0; n < 80; n++) begin
      ins = rand_instr();
      e = ref_exec(ins);
      issue(ins, o);
      checks++;
      if (!e.legal) begin
        if (o.illegal_cnt != 1 || o.en_cnt != 0 || o.retire_cnt != 0 || o.ready_low) begin
          errors++;
          $display("FAIL rand_illegal %h: ill=%0d en=%0d ret=%0d ready_low=%b required 1 0 0 0",
                   ins, o.illegal_cnt, o.en_cnt, o.retire_cnt, o.ready_low);
        end
        continue;
      end
      if ({o.f3, o.f7, o.d1, o.d2} !== {e.f3, e.f7, e.a, e.b} || o.unstable ||
          o.en_cnt != int'(L)) begin
        errors++;
        $display("FAIL rand_ops %h: f3=%h f7=%h d1=%h d2=%h en=%0d required %h %h %h %h %0d",
                 ins, o.f3, o.f7, o.d1, o.d2, o.en_cnt, e.f3, e.f7, e.a, e.b, L);
      end
      checks++;
      if (o.retire_cnt != 1 || o.rrd !== e.rd || o.rdata !== e.res || o.illegal_cnt != 0 ||
          o.ready_cycle != int'(L) + 2) begin
        errors++;
        $display("FAIL rand_retire %h: n=%0d rd=%0d data=%h rdy=%0d required 1 %0d %h %0d",
                 ins, o.retire_cnt, o.rrd, o.rdata, o.ready_cycle, e.rd, e.res, L + 2);
      end
      ref_commit(ins);
      debug_addr = e.rd;
      #1;
      checks++;
      if (debug_data !== ref_regs[e.rd]) begin
        errors++;
        $display("FAIL rand_regfile x%0d: got %h required %h", e.rd, debug_data,
                 ref_regs[e.rd]);
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached before completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_addi();
    test_sub();
    test_neg_imm();
    test_x0();
    test_illegal();
    test_busy_ignore();
    test_reset_mid_execute();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
